// File: rtl/riscv_pkg.sv
// Shared RV32I core types: fetch FSM states, machine word and the PC step.
package riscv_pkg;

  typedef logic [31:0] word_t;

  localparam word_t PC_INCR = 32'd4;

  typedef enum logic [2:0] {
    BOOT,
    REQ,
    WAIT,
    HOLD,
    TRAP
  } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: PC register, single-outstanding imem request handshake,
// valid/ready hand-off to decode, and branch/jump redirect with stale-fetch
// discard.
// Build option FETCH_MISALIGN_TRAP_EN: misaligned redirect targets enter a
// sticky TRAP state and raise misalign_trap; otherwise bits [1:0] of the
// target are cleared.
module fetch_sequencer
  import riscv_pkg::*;
#(
  parameter word_t       RESET_PC = 32'h0000_0000,
  parameter int unsigned XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  input  logic            id_ready,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic            misalign_trap,
`endif
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target
);

  fetch_state_t state, state_n;
  word_t        pc, pc_n;
  word_t        req_pc, req_pc_n;
  logic         discard, discard_n;
  logic         valid_q, valid_n;
  word_t        instr_q, instr_n;
  word_t        ipc_q, ipc_n;
  word_t        target;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic         trap_q, trap_n;
  logic         misaligned;
`endif

  // Redirect target as it will be fetched
`ifdef FETCH_MISALIGN_TRAP_EN
  assign target     = redirect_target;
  assign misaligned = |redirect_target[1:0];
`else
  assign target     = redirect_target & ~word_t'(3);
`endif

  // State register and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= BOOT;
      pc      <= RESET_PC;
      req_pc  <= '0;
      discard <= 1'b0;
      valid_q <= 1'b0;
      instr_q <= '0;
      ipc_q   <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      trap_q  <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      req_pc  <= req_pc_n;
      discard <= discard_n;
      valid_q <= valid_n;
      instr_q <= instr_n;
      ipc_q   <= ipc_n;
`ifdef FETCH_MISALIGN_TRAP_EN
      trap_q  <= trap_n;
`endif
    end
  end

  // Next-state, next-PC and output-register logic; redirect takes priority
  always_comb begin
    state_n   = state;
    pc_n      = pc;
    req_pc_n  = req_pc;
    discard_n = discard;
    valid_n   = valid_q;
    instr_n   = instr_q;
    ipc_n     = ipc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    trap_n    = trap_q;
`endif
    case (state)
      BOOT: state_n = REQ;
      REQ: begin
        if (redirect_valid) begin
          pc_n = target;
          if (imem_gnt) begin
            state_n   = WAIT;
            req_pc_n  = pc;
            discard_n = 1'b1;
          end
        end else if (imem_gnt) begin
          state_n  = WAIT;
          req_pc_n = pc;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_n = target;
          if (imem_rvalid) begin
            state_n   = REQ;
            discard_n = 1'b0;
          end else begin
            discard_n = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (discard) begin
            state_n   = REQ;
            discard_n = 1'b0;
          end else begin
            state_n = HOLD;
            valid_n = 1'b1;
            instr_n = imem_rdata;
            ipc_n   = req_pc;
          end
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          state_n = REQ;
          valid_n = 1'b0;
          pc_n    = target;
        end else if (id_ready) begin
          state_n = REQ;
          valid_n = 1'b0;
          pc_n    = ipc_q + PC_INCR;
        end
      end
      TRAP: ;
      default: state_n = BOOT;
    endcase
`ifdef FETCH_MISALIGN_TRAP_EN
    // A misaligned redirect overrides whatever the state case chose above.
    if (redirect_valid && misaligned && (state inside {REQ, WAIT, HOLD})) begin
      state_n   = TRAP;
      pc_n      = redirect_target;
      valid_n   = 1'b0;
      discard_n = 1'b0;
      trap_n    = 1'b1;
    end
`endif
  end

  assign imem_req  = (state == REQ);
  assign imem_addr = pc;
  assign if_valid  = valid_q;
  assign if_instr  = instr_q;
  assign if_pc     = ipc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign misalign_trap = trap_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
  logic        redirect_valid;
  logic [31:0] redirect_target;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign_trap;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  fetch_sequencer #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_gnt        (imem_gnt),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .if_valid        (if_valid),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .id_ready        (id_ready),
`ifdef FETCH_MISALIGN_TRAP_EN
    .misalign_trap   (misalign_trap),
`endif
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // From REQ: grant at addr, return data one cycle later, end in HOLD.
  task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] data);
    check({tag, ".req"}, {31'b0, imem_req}, 32'd1);
    check({tag, ".addr"}, imem_addr, addr);
    imem_gnt = 1'b1;
    tick;
    imem_gnt = 1'b0;
    check({tag, ".wait_req"}, {31'b0, imem_req}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    tick;
    imem_rvalid = 1'b0;
    check({tag, ".valid"}, {31'b0, if_valid}, 32'd1);
    check({tag, ".pc"}, if_pc, addr);
    check({tag, ".instr"}, if_instr, data);
  endtask

  initial begin
    rst             = 1'b1;
    imem_gnt        = 1'b0;
    imem_rvalid     = 1'b0;
    imem_rdata      = '0;
    id_ready        = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    tick;
    tick;
    check("rst.req", {31'b0, imem_req}, 32'd0);
    check("rst.addr", imem_addr, 32'h0);
    check("rst.valid", {31'b0, if_valid}, 32'd0);
    check("rst.instr", if_instr, 32'h0);
    check("rst.pc", if_pc, 32'h0);

    // BOOT cycle: no request, redirect ignored
    rst             = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0800;
    check("boot.req", {31'b0, imem_req}, 32'd0);
    tick;
    redirect_valid  = 1'b0;
    check("boot.addr", imem_addr, 32'h0);

    // Stall in HOLD for 5 cycles
    fetch("stall", 32'h0, 32'h0050_0093);
    for (int i = 0; i < 5; i++) begin
      tick;
      check("stall.valid", {31'b0, if_valid}, 32'd1);
      check("stall.instr", if_instr, 32'h0050_0093);
      check("stall.pc", if_pc, 32'h0);
      check("stall.req", {31'b0, imem_req}, 32'd0);
    end
    id_ready = 1'b1;
    tick;
    id_ready = 1'b0;
    check("accept.valid", {31'b0, if_valid}, 32'd0);
    check("accept.addr", imem_addr, 32'h4);

    // Free run, 3-cycle period
    for (int i = 0; i < 3; i++) begin
      fetch("run", 32'h4 + 32'(4 * i), 32'h1000 + 32'(i));
      id_ready = 1'b1;
      tick;
      id_ready = 1'b0;
    end

    // Redirect in WAIT, stale data arrives 3 cycles later
    check("rw.addr", imem_addr, 32'h10);
    imem_gnt = 1'b1;
    tick;
    imem_gnt        = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0100;
    tick;
    redirect_valid = 1'b0;
    check("rw.req1", {31'b0, imem_req}, 32'd0);
    tick;
    check("rw.req2", {31'b0, imem_req}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    tick;
    imem_rvalid = 1'b0;
    check("rw.valid", {31'b0, if_valid}, 32'd0);
    check("rw.req", {31'b0, imem_req}, 32'd1);
    check("rw.addr2", imem_addr, 32'h100);
    tick;
    check("rw.valid2", {31'b0, if_valid}, 32'd0);
    check("rw.hold_req", {31'b0, imem_req}, 32'd1);

    // Redirect in REQ coinciding with grant: response discarded
    imem_gnt        = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0200;
    tick;
    imem_gnt       = 1'b0;
    redirect_valid = 1'b0;
    check("rg.req", {31'b0, imem_req}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_0BAD;
    tick;
    imem_rvalid = 1'b0;
    check("rg.valid", {31'b0, if_valid}, 32'd0);
    check("rg.addr", imem_addr, 32'h200);

    // Redirect in REQ without grant: stay in REQ at new target
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0300;
    tick;
    redirect_valid = 1'b0;
    check("rq.req", {31'b0, imem_req}, 32'd1);
    check("rq.addr", imem_addr, 32'h300);

    // Redirect in HOLD with id_ready: instruction flushed
    fetch("rh", 32'h300, 32'h0000_0013);
    id_ready        = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0040;
    tick;
    id_ready       = 1'b0;
    redirect_valid = 1'b0;
    check("rh.valid", {31'b0, if_valid}, 32'd0);
    check("rh.addr", imem_addr, 32'h40);

    // PC wrap
    fetch("wrap0", 32'h40, 32'h0000_0093);
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    tick;
    redirect_valid = 1'b0;
    fetch("wrap1", 32'hFFFF_FFFC, 32'h0000_0033);
    id_ready = 1'b1;
    tick;
    id_ready = 1'b0;
    check("wrap.req", {31'b0, imem_req}, 32'd1);
    check("wrap.addr", imem_addr, 32'h0);

    // Misaligned redirect
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0102;
    tick;
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    imem_gnt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("trap.flag", {31'b0, misalign_trap}, 32'd1);
      check("trap.req", {31'b0, imem_req}, 32'd0);
      check("trap.addr", imem_addr, 32'h102);
      check("trap.valid", {31'b0, if_valid}, 32'd0);
      tick;
    end
    imem_gnt = 1'b0;
`else
    check("mis.req", {31'b0, imem_req}, 32'd1);
    check("mis.addr", imem_addr, 32'h100);
`endif

    // Reset again; stray rvalid after reset is ignored
    rst = 1'b1;
    tick;
    check("rst2.req", {31'b0, imem_req}, 32'd0);
    check("rst2.addr", imem_addr, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("rst2.trap", {31'b0, misalign_trap}, 32'd0);
`endif
    rst         = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1234_5678;
    check("rst2.boot", {31'b0, imem_req}, 32'd0);
    tick;
    check("rst2.req1", {31'b0, imem_req}, 32'd1);
    tick;
    imem_rvalid = 1'b0;
    check("rst2.req2", {31'b0, imem_req}, 32'd1);
    check("rst2.valid", {31'b0, if_valid}, 32'd0);
    check("rst2.addr2", imem_addr, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
